// File: rtl/bp_be_instr_encoder_if.sv
// Command / instruction handshake bundle for bp_be_instr_encoder.
//   cmd_*     : op descriptor in, valid/ready handshake (accept = cmd_v & cmd_ready)
//   instr_*   : encoded RV64 word out, valid/ready handshake
//   illegal   : one-cycle pulse after an illegal op is accepted
//   instr_cnt : count of output handshakes (wraps)
// modport slave  : the encoder side
// modport master : the command producer / instruction consumer side
interface bp_be_instr_encoder_if #(
  parameter int unsigned cnt_width_p = 16
);
  logic                   cmd_v;
  logic                   cmd_ready;
  logic [3:0]             cmd_op;
  logic [4:0]             cmd_rd;
  logic [4:0]             cmd_rs1;
  logic [4:0]             cmd_rs2;
  logic [31:0]            cmd_imm;
  logic                   instr_v;
  logic                   instr_ready;
  logic [31:0]            instr;
  logic                   illegal;
  logic [cnt_width_p-1:0] instr_cnt;

  modport slave (
    input  cmd_v, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
    output cmd_ready, instr_v, instr, illegal, instr_cnt
  );

  modport master (
    output cmd_v, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
    input  cmd_ready, instr_v, instr, illegal, instr_cnt
  );
endinterface

// File: rtl/bp_be_instr_encoder.sv
// Inverse of the BE instruction decoder: turns a compact op descriptor into a
// 32-bit RV64 instruction word. LI32 expands to LUI + ADDIW. Output is a
// registered valid/ready stage with one pending slot for the ADDIW half.
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   io         : bp_be_instr_encoder_if.slave (command in, instruction out,
//                illegal pulse, handshake counter)
// Parameters:
//   cnt_width_p      : width of the output-handshake counter (must match io)
//   nop_on_illegal_p : 1 = illegal op emits a NOP, 0 = it emits nothing
module bp_be_instr_encoder #(
  parameter int unsigned cnt_width_p      = 16,
  parameter bit          nop_on_illegal_p = 1'b0
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bp_be_instr_encoder_if.slave io
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_ADDI  = 4'd2,
    OP_LUI   = 4'd3,
    OP_AUIPC = 4'd4,
    OP_LD    = 4'd5,
    OP_SD    = 4'd6,
    OP_BEQ   = 4'd7,
    OP_JAL   = 4'd8,
    OP_CSRRS = 4'd9,
    OP_LI32  = 4'd10,
    OP_NOP   = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_OUT,
    ST_PEND
  } state_e;

  localparam logic [31:0] nop_word_lp = 32'h0000_0013;

  state_e                 state;
  logic                   instr_v_q;
  logic [31:0]            instr_q;
  logic [31:0]            pend_q;
  logic                   illegal_q;
  logic [cnt_width_p-1:0] cnt_q;

  logic        accept;
  logic        handshake;
  logic        illegal_op;
  logic [31:0] enc;
  logic [31:0] addiw;
  logic [19:0] li_hi;

  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign rd  = io.cmd_rd;
  assign rs1 = io.cmd_rs1;
  assign rs2 = io.cmd_rs2;
  assign imm = io.cmd_imm;

  // Never ready while the ADDIW half is pending; otherwise ready when the
  // output slot is free or draining this cycle.
  assign io.cmd_ready = (state == ST_EMPTY) | ((state == ST_OUT) & io.instr_ready);
  assign accept       = io.cmd_v & io.cmd_ready;
  assign handshake    = instr_v_q & io.instr_ready;
  assign illegal_op   = (io.cmd_op[3:2] == 2'b11);

  // ADDIW sign-extends its 12-bit immediate, so the upper part is rounded up
  // when imm[11] is set.
  assign li_hi = imm[31:12] + {19'b0, imm[11]};
  assign addiw = {imm[11:0], rd, 3'b000, rd, 7'b0011011};

  always_comb begin
    enc = nop_word_lp;
    case (io.cmd_op)
      OP_ADD:   enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:   enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_ADDI:  enc = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      OP_LUI:   enc = {imm[31:12], rd, 7'b0110111};
      OP_AUIPC: enc = {imm[31:12], rd, 7'b0010111};
      OP_LD:    enc = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      OP_SD:    enc = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      OP_BEQ:   enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      OP_JAL:   enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      OP_CSRRS: enc = {imm[11:0], rs1, 3'b010, rd, 7'b1110011};
      OP_LI32:  enc = {li_hi, rd, 7'b0110111};
      OP_NOP:   enc = nop_word_lp;
      default:  enc = nop_word_lp;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_EMPTY;
      instr_v_q <= 1'b0;
      instr_q   <= '0;
      pend_q    <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= accept & illegal_op;
      if (handshake) begin
        cnt_q <= cnt_q + cnt_width_p'(1);
      end

      if (accept) begin
        if (illegal_op) begin
          if (nop_on_illegal_p) begin
            state     <= ST_OUT;
            instr_v_q <= 1'b1;
            instr_q   <= nop_word_lp;
          end else begin
            state     <= ST_EMPTY;
            instr_v_q <= 1'b0;
          end
        end else if (io.cmd_op == OP_LI32) begin
          state     <= ST_PEND;
          instr_v_q <= 1'b1;
          instr_q   <= enc;
          pend_q    <= addiw;
        end else begin
          state     <= ST_OUT;
          instr_v_q <= 1'b1;
          instr_q   <= enc;
        end
      end else if (handshake) begin
        if (state == ST_PEND) begin
          state   <= ST_OUT;
          instr_q <= pend_q;
        end else begin
          state     <= ST_EMPTY;
          instr_v_q <= 1'b0;
        end
      end
    end
  end

  assign io.instr_v   = instr_v_q;
  assign io.instr     = instr_q;
  assign io.illegal   = illegal_q;
  assign io.instr_cnt = cnt_q;

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Bench for bp_be_instr_encoder: two instances (default parameters, and
// cnt_width_p=4 with nop_on_illegal_p=1) driven with identical stimulus and
// compared against a transaction-level model holding the expected output words.
module tb_bp_be_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_be_instr_encoder_if #(.cnt_width_p(16)) io0 ();
  bp_be_instr_encoder_if #(.cnt_width_p(4))  io1 ();

  bp_be_instr_encoder #(.cnt_width_p(16), .nop_on_illegal_p(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .io(io0.slave));
  bp_be_instr_encoder #(.cnt_width_p(4), .nop_on_illegal_p(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .io(io1.slave));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected contents of each encoder: up to two words waiting to be consumed.
  logic [31:0] exp_w   [2][2];
  int          exp_n   [2];
  bit          exp_ill [2];
  int unsigned exp_cnt [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned fld(input longint unsigned v, input int lo, input int n);
    return (v >> lo) % (64'd1 << n);
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input longint unsigned imm);
    longint unsigned w;
    case (op)
      0: w = 'h33 + rd * 128 + rs1 * 2**15 + rs2 * 2**20;
      1: w = 'h33 + rd * 128 + rs1 * 2**15 + rs2 * 2**20 + 32 * 2**25;
      2: w = 'h13 + rd * 128 + rs1 * 2**15 + fld(imm, 0, 12) * 2**20;
      3: w = 'h37 + rd * 128 + fld(imm, 12, 20) * 4096;
      4: w = 'h17 + rd * 128 + fld(imm, 12, 20) * 4096;
      5: w = 'h03 + rd * 128 + 3 * 4096 + rs1 * 2**15 + fld(imm, 0, 12) * 2**20;
      6: w = 'h23 + fld(imm, 0, 5) * 128 + 3 * 4096 + rs1 * 2**15 + rs2 * 2**20
             + fld(imm, 5, 7) * 2**25;
      7: w = 'h63 + (fld(imm, 11, 1) + fld(imm, 1, 4) * 2) * 128 + rs1 * 2**15 + rs2 * 2**20
             + (fld(imm, 5, 6) + fld(imm, 12, 1) * 64) * 2**25;
      8: w = 'h6F + rd * 128 + (fld(imm, 12, 8) + fld(imm, 11, 1) * 256 + fld(imm, 1, 10) * 512
             + fld(imm, 20, 1) * 2**19) * 4096;
      9: w = 'h73 + rd * 128 + 2 * 4096 + rs1 * 2**15 + fld(imm, 0, 12) * 2**20;
      default: w = 'h13;
    endcase
    return w[31:0];
  endfunction

  task automatic push(input int d, input logic [31:0] w);
    exp_w[d][exp_n[d]] = w;
    exp_n[d]++;
  endtask

  task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit rdy);
    io0.cmd_v = v;  io0.cmd_op = 4'(op); io0.cmd_rd = 5'(rd); io0.cmd_rs1 = 5'(rs1);
    io0.cmd_rs2 = 5'(rs2); io0.cmd_imm = imm; io0.instr_ready = rdy;
    io1.cmd_v = v;  io1.cmd_op = 4'(op); io1.cmd_rd = 5'(rd); io1.cmd_rs1 = 5'(rs1);
    io1.cmd_rs2 = 5'(rs2); io1.cmd_imm = imm; io1.instr_ready = rdy;
  endtask

  // One clock cycle: drive, compare both instances with the model, advance the model.
  task automatic cycle(input bit v, input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit rdy);
    logic        cr, iv, il;
    logic [31:0] iw, ic;
    bit          m_rdy;
    longint unsigned hi;
    @(negedge clk);
    drive(v, op, rd, rs1, rs2, imm, rdy);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        cr = io0.cmd_ready; iv = io0.instr_v; iw = io0.instr; il = io0.illegal;
        ic = 32'(io0.instr_cnt);
      end else begin
        cr = io1.cmd_ready; iv = io1.instr_v; iw = io1.instr; il = io1.illegal;
        ic = 32'(io1.instr_cnt);
      end
      m_rdy = (exp_n[d] == 0) || (exp_n[d] == 1 && rdy);
      check_eq($sformatf("cmd_ready%0d", d), {31'b0, cr}, {31'b0, m_rdy});
      check_eq($sformatf("instr_v%0d", d), {31'b0, iv}, {31'b0, exp_n[d] > 0});
      if (exp_n[d] > 0) check_eq($sformatf("instr%0d", d), iw, exp_w[d][0]);
      check_eq($sformatf("illegal%0d", d), {31'b0, il}, {31'b0, exp_ill[d]});
      check_eq($sformatf("instr_cnt%0d", d), ic, exp_cnt[d]);

      if (exp_n[d] > 0 && rdy) begin
        exp_w[d][0] = exp_w[d][1];
        exp_n[d]--;
        exp_cnt[d] = (exp_cnt[d] + 1) % (d == 0 ? 65536 : 16);
      end
      exp_ill[d] = 1'b0;
      if (v && m_rdy) begin
        if (op >= 12) begin
          exp_ill[d] = 1'b1;
          if (d == 1) push(d, 32'h13);
        end else if (op == 10) begin
          hi = (fld(imm, 12, 20) + fld(imm, 11, 1)) % (64'd1 << 20);
          push(d, 32'('h37 + rd * 128 + hi * 4096));
          push(d, 32'('h1B + rd * 128 + rd * 2**15 + fld(imm, 0, 12) * 2**20));
        end else begin
          push(d, ref_word(op, rd, rs1, rs2, imm));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    check_eq("rst_v0",   {31'b0, io0.instr_v}, 32'h0);
    check_eq("rst_v1",   {31'b0, io1.instr_v}, 32'h0);
    check_eq("rst_i0",   io0.instr, 32'h0);
    check_eq("rst_ill0", {31'b0, io0.illegal}, 32'h0);
    check_eq("rst_cnt0", 32'(io0.instr_cnt), 32'h0);
    check_eq("rst_cnt1", 32'(io1.instr_cnt), 32'h0);
    for (int d = 0; d < 2; d++) begin
      exp_n[d] = 0; exp_ill[d] = 1'b0; exp_cnt[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    cycle(1, 0, 1, 2, 3, 32'h0, 1);
    @(posedge clk); #1;
    check_eq("add_lit", io0.instr, 32'h003100B3);
    cycle(1, 6, 0, 2, 3, 32'h8, 1);
    @(posedge clk); #1;
    check_eq("sd_lit", io0.instr, 32'h00313423);

    cycle(1, 10, 5, 0, 0, 32'h12345FFF, 1);
    @(posedge clk); #1;
    check_eq("li_lui", io0.instr, 32'h123462B7);
    check_eq("li_ready", {31'b0, io0.cmd_ready}, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    @(posedge clk); #1;
    check_eq("li_addiw", io0.instr, 32'hFFF2829B);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);

    cycle(1, 15, 1, 1, 1, 32'h0, 1);
    @(posedge clk); #1;
    check_eq("ill_pulse", {31'b0, io0.illegal}, 32'h1);
    check_eq("ill_nov",   {31'b0, io0.instr_v}, 32'h0);
    check_eq("ill_nop",   io1.instr, 32'h00000013);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);

    // Stall with a command waiting behind a held output.
    cycle(1, 2, 7, 8, 0, 32'h00000ABC, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 1, 32'h0, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);

    // Back-to-back NOPs; the 4-bit counter wraps after 16 handshakes.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 11, 0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    @(posedge clk); #1;
    check_eq("cnt16_17", 32'(io0.instr_cnt), 32'd17);
    check_eq("cnt4_wrap", 32'(io1.instr_cnt), 32'd1);

    // Reset while the ADDIW half is pending.
    cycle(1, 10, 5, 0, 0, 32'h12345FFF, 0);
    @(posedge clk); #2;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
